pulse_param_loader: RTL and testbench
=====================================

Name: pulse_param_loader

Overview:
- Upstream stage of the pulse sequencer: turns the LabView byte stream (bytes from the UART receiver) into the sequencer's parameter buses.
- Parses framed register writes into shadow registers.
- On a commit frame, copies all shadows atomically into the active outputs while holding the sequencer in reset, so every pulse cycle runs with one consistent parameter set.

Parameters:
- SYNC_BYTE, 8'hAA, frame start marker.
- TIMEOUT, 200000, max clk_pll cycles between bytes inside a frame (1 ms at 200 MHz).
- HOLD_CYCLES, 4, cycles pulse_hold stays high per commit (legal range 1..255).

Ports:
- clk_pll  in  1  200 MHz PLL clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- period  out  32  active duty-cycle period.
- p1width  out  32  active first-pulse width.
- delay  out  32  active inter-pulse delay.
- p2width  out  32  active second-pulse width.
- pre_att  out  7  active pump attenuation.
- post_att  out  7  active second attenuation.
- cpmg  out  8  active mode / pi-pulse count.
- pulse_block  out  8  active post-pulse block time.
- pulse_block_off  out  16  active signal-window width.
- pump  out  1  active first-pulse enable.
- block  out  1  active blocking enable.
- pulse_hold  out  1  high = hold sequencer in reset; drives the sequencer's active-high reset input.
- frame_ok  out  1  one-cycle strobe after each accepted frame.
- frame_err  out  1  one-cycle strobe after each rejected frame.
- err_count  out  8  count of rejected frames, saturating.

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE; pulse_hold=1; frame_ok=0; frame_err=0; err_count=0.
  - Active and shadow values: period=32'd2000, p1width=32'd20, delay=32'd200, p2width=32'd40, pre_att=0, post_att=0, cpmg=8'd1, pulse_block=8'd10, pulse_block_off=16'd100, pump=1, block=1.
  - On reset release, pulse_hold runs the normal HOLD_CYCLES hold sequence, then drops.
- Frame format: SYNC_BYTE, ADDR, D0, D1, D2, D3 (little-endian 32-bit), CSUM.
  - CSUM = ADDR ^ D0 ^ D1 ^ D2 ^ D3.
- Register map:
  - 0 period, 1 p1width, 2 delay, 3 p2width: full 32 bits.
  - 4 pre_att = D0[6:0]; 5 post_att = D0[6:0]; 6 cpmg = D0; 7 pulse_block = D0.
  - 8 pulse_block_off = {D1,D0}; 9 flags: pump = D0[0], block = D0[1].
  - 0x0F commit (data ignored).
  - Unused data bits are ignored, not checked.
- FSM states: IDLE, ADDR, DATA, CSUM.
  - IDLE: a byte equal to SYNC_BYTE -> ADDR. Any other byte is discarded silently, with no error.
  - ADDR: latch the address -> DATA; byte index = 0.
  - DATA: latch bytes 0..3; after the 4th byte -> CSUM.
  - CSUM: compare the checksum and evaluate the frame -> IDLE.
    - Accept when checksum matches and address is 0..9 or 0x0F.
    - Otherwise reject (bad checksum or undefined address).
- Accepted frame:
  - The shadow write (or commit start) happens in the cycle after the CSUM byte.
  - frame_ok pulses in that same cycle.
- Rejected frame:
  - No state change.
  - frame_err pulses; err_count increments and saturates at 255.
- Timeout:
  - An inter-byte counter is cleared on each rx_valid and counts while in ADDR, DATA or CSUM.
  - When it reaches TIMEOUT: FSM -> IDLE, partial frame discarded, frame_err pulses, err_count increments.
- A SYNC_BYTE value arriving inside a frame is treated as data; there is no resynchronisation.
- Commit sequence:
  - Cycle C (cycle after the commit CSUM byte): pulse_hold rises.
  - Cycle C+1: all active outputs take their shadow values together.
  - pulse_hold stays high for exactly HOLD_CYCLES cycles starting at C, then falls, so the sequencer restarts from counter 0.
  - Active outputs change only at cycle C+1 of a commit, never otherwise.
- Shadow writes during a hold:
  - A shadow write accepted while pulse_hold=1 updates the shadow only; active outputs are unchanged until the next commit.
  - A commit accepted while pulse_hold=1 restarts the hold count (hold extends to HOLD_CYCLES from the new C) and re-copies the shadows.
- Shadow writes and a commit never complete in the same cycle, because the frame parser is serial.
- Mid-frame reset: asynchronous return to the reset state; the partial frame is lost.
- Outputs are registered; there is no combinational path from rx_* to any output.

Test Plan:
- Release reset, no bytes sent -> outputs at default values; pulse_hold high for cycles 0..3 after release, low from cycle 4 on.
- Send frame AA 01 64 00 00 00 65 (p1width = 100), then no commit -> frame_ok pulses once; p1width output stays 20.
- After that frame, send AA 0F 00 00 00 00 0F -> pulse_hold high for 4 cycles; p1width becomes 100 exactly 1 cycle after pulse_hold rises; every other output is unchanged.
- Send AA 00 10 27 00 00 00 (bad checksum; correct CSUM is 0x37) -> frame_err pulses; err_count = 1; shadow period is unchanged, confirmed by a following commit leaving period at 2000.
- Send AA 04 then stop for 200000 cycles -> frame_err pulses at the timeout; FSM is back in IDLE; a following valid frame AA 09 01 00 00 00 08 plus a commit gives pump = 1, block = 0.
- Send AA 0C 00 00 00 00 0C (undefined address) -> frame_err pulses.
- Then hold reset low in the middle of a frame -> all outputs return to their default values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pulse_param_loader.sv
// pulse_param_loader: parses framed register writes from the UART byte stream
// into shadow registers. A commit frame copies every shadow into the active
// outputs in one cycle while pulse_hold keeps the sequencer in reset.
module pulse_param_loader #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
  parameter int unsigned TIMEOUT     = 200000,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk_pll,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] period,
  output logic [31:0] p1width,
  output logic [31:0] delay,
  output logic [31:0] p2width,
  output logic [6:0]  pre_att,
  output logic [6:0]  post_att,
  output logic [7:0]  cpmg,
  output logic [7:0]  pulse_block,
  output logic [15:0] pulse_block_off,
  output logic        pump,
  output logic        block,
  output logic        pulse_hold,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  localparam int unsigned      TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
  localparam logic [7:0]       HOLD_INIT = 8'(HOLD_CYCLES - 1);

  localparam logic [31:0] DEF_PERIOD  = 32'd2000;
  localparam logic [31:0] DEF_P1WIDTH = 32'd20;
  localparam logic [31:0] DEF_DELAY   = 32'd200;
  localparam logic [31:0] DEF_P2WIDTH = 32'd40;
  localparam logic [6:0]  DEF_PRE     = 7'd0;
  localparam logic [6:0]  DEF_POST    = 7'd0;
  localparam logic [7:0]  DEF_CPMG    = 8'd1;
  localparam logic [7:0]  DEF_PB      = 8'd10;
  localparam logic [15:0] DEF_PBO     = 16'd100;
  localparam logic        DEF_PUMP    = 1'b1;
  localparam logic        DEF_BLOCK   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_CSUM = 2'd3
  } state_t;

  // XOR checksum over the address and the four data bytes
  function automatic logic [7:0] frame_csum(input logic [7:0] addr, input logic [31:0] data);
    return addr ^ data[7:0] ^ data[15:8] ^ data[23:16] ^ data[31:24];
  endfunction

  // Addresses that are part of the register map (0..9 plus commit)
  function automatic logic addr_known(input logic [7:0] addr);
    return (addr <= 8'd9) || (addr == 8'h0F);
  endfunction

  // Parser state
  state_t           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       idx_q, idx_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Shadow registers
  logic [31:0] sh_period_q, sh_period_d;
  logic [31:0] sh_p1width_q, sh_p1width_d;
  logic [31:0] sh_delay_q, sh_delay_d;
  logic [31:0] sh_p2width_q, sh_p2width_d;
  logic [6:0]  sh_pre_q, sh_pre_d;
  logic [6:0]  sh_post_q, sh_post_d;
  logic [7:0]  sh_cpmg_q, sh_cpmg_d;
  logic [7:0]  sh_pb_q, sh_pb_d;
  logic [15:0] sh_pbo_q, sh_pbo_d;
  logic        sh_pump_q, sh_pump_d;
  logic        sh_block_q, sh_block_d;

  // Active registers
  logic [31:0] period_q, period_d;
  logic [31:0] p1width_q, p1width_d;
  logic [31:0] delay_q, delay_d;
  logic [31:0] p2width_q, p2width_d;
  logic [6:0]  pre_q, pre_d;
  logic [6:0]  post_q, post_d;
  logic [7:0]  cpmg_q, cpmg_d;
  logic [7:0]  pb_q, pb_d;
  logic [15:0] pbo_q, pbo_d;
  logic        pump_q, pump_d;
  logic        block_q, block_d;

  // Commit / status
  logic       commit_pend_q, commit_pend_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       hold_q, hold_d;
  logic       frame_ok_q, frame_ok_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic accept_s;
  logic reject_s;
  logic commit_s;
  logic timeout_s;

  // Next-state logic: frame parser, shadow writes, commit and hold sequencing
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    idx_d         = idx_q;
    sh_period_d   = sh_period_q;
    sh_p1width_d  = sh_p1width_q;
    sh_delay_d    = sh_delay_q;
    sh_p2width_d  = sh_p2width_q;
    sh_pre_d      = sh_pre_q;
    sh_post_d     = sh_post_q;
    sh_cpmg_d     = sh_cpmg_q;
    sh_pb_d       = sh_pb_q;
    sh_pbo_d      = sh_pbo_q;
    sh_pump_d     = sh_pump_q;
    sh_block_d    = sh_block_q;
    period_d      = period_q;
    p1width_d     = p1width_q;
    delay_d       = delay_q;
    p2width_d     = p2width_q;
    pre_d         = pre_q;
    post_d        = post_q;
    cpmg_d        = cpmg_q;
    pb_d          = pb_q;
    pbo_d         = pbo_q;
    pump_d        = pump_q;
    block_d       = block_q;
    commit_pend_d = 1'b0;
    hold_cnt_d    = hold_cnt_q;
    hold_d        = hold_q;
    frame_ok_d    = 1'b0;
    frame_err_d   = 1'b0;
    err_cnt_d     = err_cnt_q;
    accept_s      = 1'b0;
    reject_s      = 1'b0;
    commit_s      = 1'b0;

    // Inter-byte watchdog: restarts on every byte, idle outside a frame
    if (rx_valid || (state_q == S_IDLE)) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TMO_ONE;
    end
    timeout_s = (state_q != S_IDLE) && !rx_valid && (tmo_cnt_q == TMO_LAST);

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          idx_d   = 2'd0;
          state_d = S_DATA;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          // Little-endian: shifting in from the top leaves D0 in [7:0]
          data_d = {rx_data, data_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          state_d = S_IDLE;
          if ((rx_data == frame_csum(addr_q, data_q)) && addr_known(addr_q)) begin
            accept_s = 1'b1;
          end else begin
            reject_s = 1'b1;
          end
        end else begin
          state_d = S_CSUM;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (timeout_s) begin
      state_d  = S_IDLE;
      reject_s = 1'b1;
    end else begin
      state_d = state_d;
    end

    if (accept_s) begin
      frame_ok_d = 1'b1;
      case (addr_q)
        8'd0:    sh_period_d  = data_q;
        8'd1:    sh_p1width_d = data_q;
        8'd2:    sh_delay_d   = data_q;
        8'd3:    sh_p2width_d = data_q;
        8'd4:    sh_pre_d     = data_q[6:0];
        8'd5:    sh_post_d    = data_q[6:0];
        8'd6:    sh_cpmg_d    = data_q[7:0];
        8'd7:    sh_pb_d      = data_q[7:0];
        8'd8:    sh_pbo_d     = data_q[15:0];
        8'd9: begin
          sh_pump_d  = data_q[0];
          sh_block_d = data_q[1];
        end
        8'h0F:   commit_s = 1'b1;
        default: commit_s = 1'b0;
      endcase
    end else begin
      frame_ok_d = 1'b0;
    end

    if (reject_s) begin
      frame_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      frame_err_d = 1'b0;
    end

    // Hold covers HOLD_CYCLES cycles from the commit; a new commit restarts it
    if (commit_s) begin
      hold_d        = 1'b1;
      hold_cnt_d    = HOLD_INIT;
      commit_pend_d = 1'b1;
    end else if (hold_cnt_q != 8'd0) begin
      hold_d     = 1'b1;
      hold_cnt_d = hold_cnt_q - 8'd1;
    end else begin
      hold_d     = 1'b0;
      hold_cnt_d = 8'd0;
    end

    // Active set is loaded in one cycle, the cycle after pulse_hold rises
    if (commit_pend_q) begin
      period_d  = sh_period_q;
      p1width_d = sh_p1width_q;
      delay_d   = sh_delay_q;
      p2width_d = sh_p2width_q;
      pre_d     = sh_pre_q;
      post_d    = sh_post_q;
      cpmg_d    = sh_cpmg_q;
      pb_d      = sh_pb_q;
      pbo_d     = sh_pbo_q;
      pump_d    = sh_pump_q;
      block_d   = sh_block_q;
    end else begin
      period_d  = period_q;
    end
  end

  // State registers with asynchronous reset to the power-on parameter set
  always_ff @(posedge clk_pll or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      addr_q        <= 8'd0;
      data_q        <= 32'd0;
      idx_q         <= 2'd0;
      tmo_cnt_q     <= '0;
      sh_period_q   <= DEF_PERIOD;
      sh_p1width_q  <= DEF_P1WIDTH;
      sh_delay_q    <= DEF_DELAY;
      sh_p2width_q  <= DEF_P2WIDTH;
      sh_pre_q      <= DEF_PRE;
      sh_post_q     <= DEF_POST;
      sh_cpmg_q     <= DEF_CPMG;
      sh_pb_q       <= DEF_PB;
      sh_pbo_q      <= DEF_PBO;
      sh_pump_q     <= DEF_PUMP;
      sh_block_q    <= DEF_BLOCK;
      period_q      <= DEF_PERIOD;
      p1width_q     <= DEF_P1WIDTH;
      delay_q       <= DEF_DELAY;
      p2width_q     <= DEF_P2WIDTH;
      pre_q         <= DEF_PRE;
      post_q        <= DEF_POST;
      cpmg_q        <= DEF_CPMG;
      pb_q          <= DEF_PB;
      pbo_q         <= DEF_PBO;
      pump_q        <= DEF_PUMP;
      block_q       <= DEF_BLOCK;
      commit_pend_q <= 1'b0;
      hold_cnt_q    <= HOLD_INIT;
      hold_q        <= 1'b1;
      frame_ok_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      err_cnt_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      idx_q         <= idx_d;
      tmo_cnt_q     <= tmo_cnt_d;
      sh_period_q   <= sh_period_d;
      sh_p1width_q  <= sh_p1width_d;
      sh_delay_q    <= sh_delay_d;
      sh_p2width_q  <= sh_p2width_d;
      sh_pre_q      <= sh_pre_d;
      sh_post_q     <= sh_post_d;
      sh_cpmg_q     <= sh_cpmg_d;
      sh_pb_q       <= sh_pb_d;
      sh_pbo_q      <= sh_pbo_d;
      sh_pump_q     <= sh_pump_d;
      sh_block_q    <= sh_block_d;
      period_q      <= period_d;
      p1width_q     <= p1width_d;
      delay_q       <= delay_d;
      p2width_q     <= p2width_d;
      pre_q         <= pre_d;
      post_q        <= post_d;
      cpmg_q        <= cpmg_d;
      pb_q          <= pb_d;
      pbo_q         <= pbo_d;
      pump_q        <= pump_d;
      block_q       <= block_d;
      commit_pend_q <= commit_pend_d;
      hold_cnt_q    <= hold_cnt_d;
      hold_q        <= hold_d;
      frame_ok_q    <= frame_ok_d;
      frame_err_q   <= frame_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign period          = period_q;
  assign p1width         = p1width_q;
  assign delay           = delay_q;
  assign p2width         = p2width_q;
  assign pre_att         = pre_q;
  assign post_att        = post_q;
  assign cpmg            = cpmg_q;
  assign pulse_block     = pb_q;
  assign pulse_block_off = pbo_q;
  assign pump            = pump_q;
  assign block           = block_q;
  assign pulse_hold      = hold_q;
  assign frame_ok        = frame_ok_q;
  assign frame_err       = frame_err_q;
  assign err_count       = err_cnt_q;

endmodule

// File: tb/tb_pulse_param_loader.sv
// Scoreboard bench for pulse_param_loader: frame verdicts and the expected
// shadow/active parameter set are modelled from the bytes the bench sends.
module tb_pulse_param_loader;

  localparam int TMO  = 1000;
  localparam int HOLD = 4;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] p1width;
    logic [31:0] delay;
    logic [31:0] p2width;
    logic [6:0]  pre_att;
    logic [6:0]  post_att;
    logic [7:0]  cpmg;
    logic [7:0]  pulse_block;
    logic [15:0] pulse_block_off;
    logic        pump;
    logic        block;
  } params_t;

  logic        clk_pll = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] period, p1width, delay, p2width;
  logic [6:0]  pre_att, post_att;
  logic [7:0]  cpmg, pulse_block;
  logic [15:0] pulse_block_off;
  logic        pump, block, pulse_hold, frame_ok, frame_err;
  logic [7:0]  err_count;

  int      checks   = 0;
  int      failures = 0;
  bit      exp_q[$];
  params_t m_shadow, m_active;
  int      m_errs;

  always #5 clk_pll = ~clk_pll;

  pulse_param_loader #(.SYNC_BYTE(8'hAA), .TIMEOUT(TMO), .HOLD_CYCLES(HOLD)) dut (
    .clk_pll(clk_pll), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .period(period), .p1width(p1width), .delay(delay), .p2width(p2width),
    .pre_att(pre_att), .post_att(post_att), .cpmg(cpmg), .pulse_block(pulse_block),
    .pulse_block_off(pulse_block_off), .pump(pump), .block(block),
    .pulse_hold(pulse_hold), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_count(err_count)
  );

  function automatic params_t defaults();
    params_t p;
    p.period = 32'd2000; p.p1width = 32'd20; p.delay = 32'd200; p.p2width = 32'd40;
    p.pre_att = 7'd0; p.post_att = 7'd0; p.cpmg = 8'd1; p.pulse_block = 8'd10;
    p.pulse_block_off = 16'd100; p.pump = 1'b1; p.block = 1'b1;
    return p;
  endfunction

  function automatic params_t observed();
    params_t p;
    p.period = period; p.p1width = p1width; p.delay = delay; p.p2width = p2width;
    p.pre_att = pre_att; p.post_att = post_att; p.cpmg = cpmg; p.pulse_block = pulse_block;
    p.pulse_block_off = pulse_block_off; p.pump = pump; p.block = block;
    return p;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_pll);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_pll);
    rx_valid = 1'b0;
  endtask

  // Drives one frame and pushes the expected verdict; updates the model
  task automatic send_frame(input logic [7:0] addr, input logic [31:0] data, input logic [7:0] cs);
    bit ok;
    ok = (cs == (addr ^ data[7:0] ^ data[15:8] ^ data[23:16] ^ data[31:24])) &&
         ((addr <= 8'd9) || (addr == 8'h0F));
    exp_q.push_back(ok);
    if (ok) begin
      case (addr)
        8'd0: m_shadow.period = data;
        8'd1: m_shadow.p1width = data;
        8'd2: m_shadow.delay = data;
        8'd3: m_shadow.p2width = data;
        8'd4: m_shadow.pre_att = data[6:0];
        8'd5: m_shadow.post_att = data[6:0];
        8'd6: m_shadow.cpmg = data[7:0];
        8'd7: m_shadow.pulse_block = data[7:0];
        8'd8: m_shadow.pulse_block_off = data[15:0];
        8'd9: begin m_shadow.pump = data[0]; m_shadow.block = data[1]; end
        default: m_active = m_shadow;
      endcase
    end else begin
      m_errs = (m_errs == 255) ? 255 : m_errs + 1;
    end
    send_byte(8'hAA);
    send_byte(addr);
    send_byte(data[7:0]);
    send_byte(data[15:8]);
    send_byte(data[23:16]);
    send_byte(data[31:24]);
    send_byte(cs);
  endtask

  // Observes the next verdict strobe within a cycle budget
  task automatic await_result(input int budget, output bit got_ok, output bit got_err, output int waited);
    waited = 0;
    while (!frame_ok && !frame_err && waited < budget) begin
      @(negedge clk_pll);
      waited++;
    end
    got_ok  = frame_ok;
    got_err = frame_err;
  endtask

  task automatic test_reset();
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    m_shadow = defaults(); m_active = defaults(); m_errs = 0;
    repeat (3) @(negedge clk_pll);
    checks++;
    if (observed() !== defaults() || pulse_hold !== 1'b1 || frame_ok !== 1'b0 ||
        frame_err !== 1'b0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_state got=%h hold=%b ok=%b err=%b ec=%0d exp=%h hold=1", observed(), pulse_hold, frame_ok, frame_err, err_count, defaults());
    end
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (pulse_hold !== (i < HOLD) || observed() !== defaults()) begin
        failures++;
        $display("FAIL reset_hold cycle=%0d got=%b exp=%b", i, pulse_hold, (i < HOLD));
      end
      @(negedge clk_pll);
    end
  endtask

  task automatic test_idle_garbage();
    int quiet;
    send_byte(8'h55); send_byte(8'h0F); send_byte(8'hFF);
    quiet = 1;
    for (int i = 0; i < 5; i++) begin
      if (frame_ok !== 1'b0 || frame_err !== 1'b0) quiet = 0;
      @(negedge clk_pll);
    end
    checks++;
    if (quiet != 1 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL idle_garbage got quiet=%0d ec=%0d exp quiet=1 ec=0", quiet, err_count);
    end
  endtask

  task automatic test_shadow_write();
    bit ok, err; int w; bit e;
    send_frame(8'h01, 32'h0000_0064, 8'h65);
    await_result(20, ok, err, w);
    e = exp_q.pop_front();
    checks++;
    if (ok !== e || err !== !e || w != 0) begin
      failures++;
      $display("FAIL shadow_write_verdict got ok=%b err=%b wait=%0d exp ok=%b wait=0", ok, err, w, e);
    end
    @(negedge clk_pll);
    checks++;
    if (frame_ok !== 1'b0 || observed() !== m_active || p1width !== 32'd20) begin
      failures++;
      $display("FAIL shadow_no_effect got ok=%b p=%h exp ok=0 p=%h", frame_ok, observed(), m_active);
    end
  endtask

  task automatic test_commit();
    bit ok, err; int w; bit e; params_t pre; int highs; int last_hi;
    pre = observed();
    send_frame(8'h0F, 32'h0000_0000, 8'h0F);
    await_result(20, ok, err, w);
    e = exp_q.pop_front();
    checks++;
    if (ok !== e || err !== 1'b0 || w != 0) begin
      failures++;
      $display("FAIL commit_verdict got ok=%b err=%b wait=%0d exp ok=%b wait=0", ok, err, w, e);
    end
    checks++;
    if (pulse_hold !== 1'b1 || observed() !== pre) begin
      failures++;
      $display("FAIL commit_cycle_c got hold=%b p=%h exp hold=1 p=%h", pulse_hold, observed(), pre);
    end
    highs = 1; last_hi = 0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk_pll);
      if (i == 1) begin
        checks++;
        if (observed() !== m_active) begin
          failures++;
          $display("FAIL commit_apply got=%h exp=%h", observed(), m_active);
        end
      end
      if (pulse_hold) begin highs++; last_hi = i; end
    end
    checks++;
    if (highs != HOLD || last_hi != HOLD - 1 || observed() !== m_active) begin
      failures++;
      $display("FAIL commit_hold_len got highs=%0d last=%0d exp highs=%0d last=%0d", highs, last_hi, HOLD, HOLD - 1);
    end
  endtask

  task automatic test_bad_csum();
    bit ok, err; int w; bit e;
    send_frame(8'h00, 32'h0000_2710, 8'h00);
    await_result(20, ok, err, w);
    e = exp_q.pop_front();
    checks++;
    if (ok !== e || err !== !e || w != 0 || err_count !== 8'(m_errs)) begin
      failures++;
      $display("FAIL bad_csum got ok=%b err=%b ec=%0d exp ok=%b ec=%0d", ok, err, err_count, e, m_errs);
    end
    test_commit();
    checks++;
    if (period !== 32'd2000) begin
      failures++;
      $display("FAIL bad_csum_period got=%0d exp=2000", period);
    end
  endtask

  task automatic test_timeout();
    bit ok, err; int w;
    send_byte(8'hAA);
    send_byte(8'h04);
    await_result(TMO + 20, ok, err, w);
    m_errs = (m_errs == 255) ? 255 : m_errs + 1;
    checks++;
    if (ok !== 1'b0 || err !== 1'b1 || w < TMO - 2 || w > TMO + 2 || err_count !== 8'(m_errs)) begin
      failures++;
      $display("FAIL timeout got ok=%b err=%b wait=%0d ec=%0d exp err=1 wait~%0d ec=%0d", ok, err, w, err_count, TMO, m_errs);
    end
    send_frame(8'h09, 32'h0000_0001, 8'h08);
    await_result(20, ok, err, w);
    checks++;
    if (ok !== exp_q.pop_front() || err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_recover got ok=%b err=%b exp ok=1 err=0", ok, err);
    end
    test_commit();
    checks++;
    if (pump !== 1'b1 || block !== 1'b0) begin
      failures++;
      $display("FAIL flags got pump=%b block=%b exp pump=1 block=0", pump, block);
    end
  endtask

  task automatic test_undef_addr();
    bit ok, err; int w; bit e;
    send_frame(8'h0C, 32'h0000_0000, 8'h0C);
    await_result(20, ok, err, w);
    e = exp_q.pop_front();
    checks++;
    if (ok !== e || err !== !e || err_count !== 8'(m_errs)) begin
      failures++;
      $display("FAIL undef_addr got ok=%b err=%b ec=%0d exp ok=%b ec=%0d", ok, err, err_count, e, m_errs);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, err; int w; bit e;
    logic [31:0] vals[10];
    logic [31:0] d;
    logic [7:0]  a;
    vals[0] = 32'h0001_86A0; vals[1] = 32'h0000_0033; vals[2] = 32'hDEAD_BEEF;
    vals[3] = 32'h1234_5678; vals[4] = 32'h0000_00FF; vals[5] = 32'h0000_0045;
    vals[6] = 32'h0000_00AA; vals[7] = 32'h0000_00AA; vals[8] = 32'h5555_1234;
    vals[9] = 32'h0000_0002;
    for (int i = 0; i < 10; i++) begin
      a = 8'(i);
      d = vals[i];
      send_frame(a, d, a ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24]);
      await_result(20, ok, err, w);
      e = exp_q.pop_front();
      checks++;
      if (ok !== e || err !== !e || w != 0 || observed() !== m_active) begin
        failures++;
        $display("FAIL b2b_write addr=%0d got ok=%b err=%b p=%h exp ok=%b p=%h", i, ok, err, observed(), e, m_active);
      end
    end
    test_commit();
    checks++;
    if (pre_att !== 7'h7F || pulse_block !== 8'hAA || pulse_block_off !== 16'h1234) begin
      failures++;
      $display("FAIL b2b_fields got pre=%h pb=%h pbo=%h exp pre=7f pb=aa pbo=1234", pre_att, pulse_block, pulse_block_off);
    end
  endtask

  task automatic test_err_saturate();
    bit ok, err; int w; int bad;
    bad = 0;
    while (m_errs < 255) begin
      send_frame(8'h03, 32'h0000_0000, 8'h00);
      await_result(20, ok, err, w);
      if (exp_q.pop_front() !== 1'b0 || err !== 1'b1) bad++;
    end
    send_frame(8'h03, 32'h0000_0000, 8'h00);
    await_result(20, ok, err, w);
    void'(exp_q.pop_front());
    checks++;
    if (bad != 0 || err !== 1'b1 || err_count !== 8'd255) begin
      failures++;
      $display("FAIL err_saturate got bad=%0d err=%b ec=%0d exp bad=0 err=1 ec=255", bad, err, err_count);
    end
  endtask

  task automatic test_midframe_reset();
    bit ok, err; int w;
    send_byte(8'hAA);
    send_byte(8'h01);
    @(posedge clk_pll);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (observed() !== defaults() || pulse_hold !== 1'b1 || err_count !== 8'd0 ||
        frame_ok !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL midframe_reset got=%h hold=%b ec=%0d exp=%h hold=1 ec=0", observed(), pulse_hold, err_count, defaults());
    end
    exp_q.delete();
    m_shadow = defaults(); m_active = defaults(); m_errs = 0;
    @(negedge clk_pll);
    reset = 1'b1;
    repeat (HOLD + 2) @(negedge clk_pll);
    send_frame(8'h02, 32'h0000_0321, 8'h02 ^ 8'h21 ^ 8'h03);
    await_result(20, ok, err, w);
    checks++;
    if (ok !== exp_q.pop_front() || err !== 1'b0 || observed() !== defaults()) begin
      failures++;
      $display("FAIL post_reset_frame got ok=%b err=%b exp ok=1 err=0", ok, err);
    end
    test_commit();
  endtask

  initial begin
    test_reset();
    test_idle_garbage();
    test_shadow_write();
    test_commit();
    test_bad_csum();
    test_timeout();
    test_undef_addr();
    test_back_to_back();
    test_err_saturate();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
